mem_arbiter: RTL and testbench

Two-requester arbiter that shares one unified memory port between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. It serialises accesses through a three-state FSM, gives data accesses priority, bounds instruction-fetch starvation, and produces per-stage stall signals for the pipeline control.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and
// data memory. Data accesses win conflicts, except that fetch wins once after
// STARVE_MAX consecutive conflict losses. One access is outstanding at a time.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    // Instruction-fetch requester
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IGrant,
    output logic        IValid,
    output logic [31:0] IData,
    output logic        IStall,
    // Data-memory requester
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DGrant,
    output logic        DValid,
    output logic [31:0] DRData,
    output logic        DStall,
    // Shared memory port
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       ireq_e, dreq_e;
    logic       issue_i, issue_d;
    logic       done_i, done_d;

    // A requester is masked in its own completion cycle so a request held
    // through valid is not issued a second time.
    assign ireq_e = IReq & ~IValid;
    assign dreq_e = DReq & ~DValid;

    // Stalls follow the raw request until its valid pulse.
    assign IStall = IReq & ~IValid;
    assign DStall = DReq & ~DValid;

    // Next-state logic: arbitration in idle, completion detection when busy.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        issue_i  = 1'b0;
        issue_d  = 1'b0;
        done_i   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ireq_e && dreq_e) begin
                    if (starve_q == StarveMax) begin
                        issue_i = 1'b1;
                    end else begin
                        issue_d = 1'b1;
                        if (starve_q < StarveMax) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end else if (dreq_e) begin
                    issue_d = 1'b1;
                end else if (ireq_e) begin
                    issue_i = 1'b1;
                end
                if (issue_i) begin
                    state_d  = StBusyI;
                    starve_d = 4'd0;
                end else if (issue_d) begin
                    state_d = StBusyD;
                end
            end
            StBusyI: begin
                if (MemAck) begin
                    done_i  = 1'b1;
                    state_d = StIdle;
                end
            end
            StBusyD: begin
                if (MemAck) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and starvation counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Memory port registers, grant/valid pulses and captured read data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MemReq   <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= 32'd0;
            MemWData <= 32'd0;
            IGrant   <= 1'b0;
            DGrant   <= 1'b0;
            IValid   <= 1'b0;
            DValid   <= 1'b0;
            IData    <= 32'd0;
            DRData   <= 32'd0;
        end else begin
            IGrant <= issue_i;
            DGrant <= issue_d;
            IValid <= done_i;
            DValid <= done_d;
            if (issue_i) begin
                MemReq   <= 1'b1;
                MemWrite <= 1'b0;
                MemAddr  <= IAddr;
                MemWData <= 32'd0;
            end else if (issue_d) begin
                MemReq   <= 1'b1;
                MemWrite <= DWrite;
                MemAddr  <= DAddr;
                MemWData <= DWData;
            end else if (done_i || done_d) begin
                MemReq <= 1'b0;
            end
            if (done_i) begin
                IData <= MemRData;
            end
            // Stores complete without touching the load data register.
            if (done_d && !MemWrite) begin
                DRData <= MemRData;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-word memory model.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IReq, DReq, DWrite, MemAck;
    logic [31:0] IAddr, DAddr, DWData, MemRData;
    logic        IGrant, IValid, IStall, DGrant, DValid, DStall;
    logic        MemReq, MemWrite;
    logic [31:0] IData, DRData, MemAddr, MemWData;

    int          checks = 0;
    int          passed = 0;

    // Memory model: acks when MemReq has been high for ack_lat cycles.
    int          ack_lat   = 1;
    int          mem_cnt   = 0;
    logic        force_ack = 1'b0;
    logic [31:0] mem_word  = 32'd0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IGrant   (IGrant),
        .IValid   (IValid),
        .IData    (IData),
        .IStall   (IStall),
        .DReq     (DReq),
        .DWrite   (DWrite),
        .DAddr    (DAddr),
        .DWData   (DWData),
        .DGrant   (DGrant),
        .DValid   (DValid),
        .DRData   (DRData),
        .DStall   (DStall),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemAck   (MemAck),
        .MemRData (MemRData)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle, then let the memory model respond to the new state.
    task automatic step();
        @(posedge Clk);
        #1;
        if (MemReq) begin
            mem_cnt++;
            if (mem_cnt == ack_lat) begin
                MemAck = 1'b1;
                if (MemWrite) mem_word = MemWData;
                MemRData = MemWrite ? 32'd0 : mem_word;
            end else begin
                MemAck   = 1'b0;
                MemRData = 32'd0;
            end
        end else begin
            mem_cnt  = 0;
            MemAck   = force_ack;
            MemRData = force_ack ? 32'h1234_5678 : 32'd0;
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++;
        if ({MemReq, MemWrite, IGrant, DGrant, IValid, DValid, IStall, DStall} !== 8'd0)
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {MemReq, MemWrite, IGrant, DGrant, IValid, DValid, IStall, DStall});
        else passed++;
        Reset = 1'b0;
        step();
        checks++;
        if ({MemAddr, MemWData, IData, DRData} !== 128'd0)
            $display("FAIL reset_data: got %h expected 0", {MemAddr, MemWData, IData, DRData});
        else passed++;
    endtask

    task automatic test_lone_fetch();
        int          stall_n = 0, grant_n = 0, valid_n = 0, grant_at = 0, valid_at = 0;
        logic [31:0] addr_g = 32'd0, wd_g = 32'hffff_ffff, data_v = 32'd0;
        logic        wr_g = 1'b1;
        mem_word = 32'h8C01_0004;
        ack_lat  = 3;
        IAddr    = 32'h40;
        IReq     = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (IStall) stall_n++;
            step();
            if (IGrant) begin
                grant_n++; grant_at = c; addr_g = MemAddr; wr_g = MemWrite; wd_g = MemWData;
            end
            if (IValid) begin
                valid_n++; valid_at = c; data_v = IData; IReq = 1'b0;
            end
        end
        checks++;
        if (grant_n !== 1) $display("FAIL fetch_grant_count: got %0d expected 1", grant_n);
        else passed++;
        checks++;
        if (grant_at !== 1) $display("FAIL fetch_grant_cycle: got %0d expected 1", grant_at);
        else passed++;
        checks++;
        if (addr_g !== 32'h40) $display("FAIL fetch_mem_addr: got %h expected 00000040", addr_g);
        else passed++;
        checks++;
        if ({wr_g, wd_g} !== 33'd0)
            $display("FAIL fetch_mem_write: got %b/%h expected 0/00000000", wr_g, wd_g);
        else passed++;
        checks++;
        if (valid_n !== 1 || valid_at !== 4)
            $display("FAIL fetch_valid: got count %0d cycle %0d expected 1 at 4", valid_n, valid_at);
        else passed++;
        checks++;
        if (data_v !== 32'h8C01_0004) $display("FAIL fetch_data: got %h expected 8c010004", data_v);
        else passed++;
        checks++;
        if (stall_n !== 4) $display("FAIL fetch_stall_cycles: got %0d expected 4", stall_n);
        else passed++;
    endtask

    task automatic test_store_load();
        logic        wr_g = 1'b0, valid_s = 1'b0, valid_l = 1'b0;
        logic [31:0] addr_g = 32'd0, wd_g = 32'd0, rd_s = 32'hffff_ffff, rd_l = 32'd0;
        ack_lat = 2;
        DWrite  = 1'b1;
        DAddr   = 32'h100;
        DWData  = 32'hDEAD_BEEF;
        DReq    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (DGrant) begin
                wr_g = MemWrite; addr_g = MemAddr; wd_g = MemWData;
            end
            if (DValid) begin
                valid_s = 1'b1; rd_s = DRData; DReq = 1'b0;
            end
        end
        checks++;
        if ({wr_g, addr_g, wd_g} !== {1'b1, 32'h100, 32'hDEAD_BEEF})
            $display("FAIL store_issue: got w=%b a=%h d=%h expected w=1 a=00000100 d=deadbeef",
                     wr_g, addr_g, wd_g);
        else passed++;
        checks++;
        if (valid_s !== 1'b1 || rd_s !== 32'd0)
            $display("FAIL store_done: got valid %b rdata %h expected 1 00000000", valid_s, rd_s);
        else passed++;
        DWrite = 1'b0;
        DWData = 32'd0;
        DReq   = 1'b1;
        wr_g   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (DGrant) wr_g = MemWrite;
            if (DValid) begin
                valid_l = 1'b1; rd_l = DRData; DReq = 1'b0;
            end
        end
        checks++;
        if (wr_g !== 1'b0) $display("FAIL load_mem_write: got %b expected 0", wr_g);
        else passed++;
        checks++;
        if (valid_l !== 1'b1 || rd_l !== 32'hDEAD_BEEF)
            $display("FAIL load_data: got valid %b rdata %h expected 1 deadbeef", valid_l, rd_l);
        else passed++;
    endtask

    // Both sides present a fresh request every cycle except a completion cycle,
    // so every arbitration edge after the first is a genuine conflict.
    task automatic test_starvation();
        logic [9:0] order = 10'd0;
        int         ng = 0, niv = 0, ndv = 0;
        ack_lat = 1;
        IAddr   = 32'h200;
        DAddr   = 32'h300;
        DWrite  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            IReq = (ng < 10) && !(IValid || DValid);
            DReq = IReq;
            step();
            if (IGrant || DGrant) begin
                order = {order[8:0], IGrant};
                ng++;
            end
            if (IValid) niv++;
            if (DValid) ndv++;
        end
        IReq = 1'b0;
        DReq = 1'b0;
        checks++;
        if (ng !== 10 || order !== 10'b0000100001)
            $display("FAIL starve_order: got %0d grants %b expected 10 0000100001 (1=I)", ng, order);
        else passed++;
        checks++;
        if (niv !== 2 || ndv !== 8)
            $display("FAIL starve_valids: got I=%0d D=%0d expected I=2 D=8", niv, ndv);
        else passed++;
        checks++;
        if (MemReq !== 1'b0) $display("FAIL starve_drain: got MemReq %b expected 0", MemReq);
        else passed++;
    endtask

    task automatic test_masking();
        logic [8:0] g = 9'd0, v = 9'd0;
        ack_lat = 1;
        IAddr   = 32'h44;
        DReq    = 1'b0;
        for (int c = 0; c < 8; c++) begin
            IReq = (c <= 3);
            step();
            g[c+1] = IGrant;
            v[c+1] = IValid;
        end
        IReq = 1'b0;
        checks++;
        if (g !== 9'b000010010) $display("FAIL mask_grants: got %b expected 000010010", g);
        else passed++;
        checks++;
        if (v !== 9'b000100100) $display("FAIL mask_valids: got %b expected 000100100", v);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int          dv_rst = 0, dv_after = 0;
        logic [31:0] rd = 32'd0;
        ack_lat = 5;
        DWrite  = 1'b0;
        DAddr   = 32'h300;
        DReq    = 1'b1;
        step();
        checks++;
        if (DGrant !== 1'b1 || MemReq !== 1'b1)
            $display("FAIL rmid_issue: got grant %b req %b expected 1 1", DGrant, MemReq);
        else passed++;
        step();
        Reset = 1'b1;
        #1;
        checks++;
        if (MemReq !== 1'b0) $display("FAIL rmid_memreq: got %b expected 0", MemReq);
        else passed++;
        checks++;
        if ({MemWrite, IGrant, DGrant, IValid, DValid, MemAddr, MemWData, IData, DRData} !== 133'd0)
            $display("FAIL rmid_outputs: got %h expected 0",
                     {MemWrite, IGrant, DGrant, IValid, DValid, MemAddr, MemWData, IData, DRData});
        else passed++;
        for (int c = 0; c < 3; c++) begin
            step();
            if (DValid) dv_rst++;
        end
        Reset = 1'b0;
        step();
        checks++;
        if (DGrant !== 1'b1 || MemAddr !== 32'h300)
            $display("FAIL rmid_reissue: got grant %b addr %h expected 1 00000300", DGrant, MemAddr);
        else passed++;
        for (int c = 0; c < 8; c++) begin
            step();
            if (DValid) begin
                dv_after++; rd = DRData; DReq = 1'b0;
            end
        end
        checks++;
        if (dv_rst !== 0 || dv_after !== 1)
            $display("FAIL rmid_valid: got %0d during reset %0d after expected 0 1", dv_rst, dv_after);
        else passed++;
        checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL rmid_data: got %h expected deadbeef", rd);
        else passed++;
    endtask

    task automatic test_spurious();
        int vcount = 0;
        IReq = 1'b0;
        DReq = 1'b0;
        step();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (IValid || DValid || MemReq) vcount++;
        end
        checks++;
        if (vcount !== 0) $display("FAIL spur_activity: got %0d active cycles expected 0", vcount);
        else passed++;
        checks++;
        if (IData !== 32'd0 || DRData !== 32'hDEAD_BEEF)
            $display("FAIL spur_data: got %h %h expected 00000000 deadbeef", IData, DRData);
        else passed++;
        // A fetch issued with one-cycle latency shows the FSM stayed idle.
        ack_lat  = 1;
        mem_word = 32'hCAFE_0001;
        IAddr    = 32'h80;
        IReq     = 1'b1;
        step();
        checks++;
        if (IGrant !== 1'b1) $display("FAIL spur_idle_grant: got %b expected 1", IGrant);
        else passed++;
        step();
        IReq = 1'b0;
        checks++;
        if (IValid !== 1'b1 || IData !== 32'hCAFE_0001)
            $display("FAIL spur_fetch: got valid %b data %h expected 1 cafe0001", IValid, IData);
        else passed++;
        step();
    endtask

    initial begin
        Reset    = 1'b1;
        IReq     = 1'b0;
        DReq     = 1'b0;
        DWrite   = 1'b0;
        IAddr    = 32'd0;
        DAddr    = 32'd0;
        DWData   = 32'd0;
        MemAck   = 1'b0;
        MemRData = 32'd0;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_starvation();
        test_masking();
        test_reset_mid();
        test_spurious();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
